// File: rtl/oflow_score_board_rr_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// oflow_arb_pkg
// Shared constants and types for the score-board round-robin arbiter.
//   PE_NUM    : number of PE requesters per set
//   ID_LEN    : width of the object ID written to the score board
//   ROW_LEN   : width of the score-board row select
//   PE_IDX_W  : width of a PE index
//   arb_state_t : arbiter FSM states
//   next_idx()  : PE index increment with wrap at PE_NUM-1
// ---------------------------------------------------------------------------
package oflow_arb_pkg;

  localparam int PE_NUM   = 8;
  localparam int ID_LEN   = 12;
  localparam int ROW_LEN  = 5;
  localparam int PE_IDX_W = $clog2(PE_NUM);

  typedef enum logic [1:0] {IDLE, ARB, WAIT, DONE} arb_state_t;

  // Explicit wrap so the pointer stays legal even when PE_NUM is not a power of two.
  function automatic logic [PE_IDX_W-1:0] next_idx(input logic [PE_IDX_W-1:0] idx);
    if (idx == PE_IDX_W'(PE_NUM - 1)) begin
      return '0;
    end
    return idx + 1'b1;
  endfunction

endpackage

// File: rtl/oflow_score_board_rr_arbiter_if.sv
// ---------------------------------------------------------------------------
// oflow_score_board_rr_arbiter_if
// Bundles the PE-array side and the score-board write side of the arbiter.
//   master : the environment (PE array + score board) view
//   slave  : the arbiter view
// Signals: start_registration, pe_valid_mask, row_sel, pe_req, pe_id,
//          pe_grant, sb_wr_valid, sb_wr_ready, sb_wr_pe, sb_wr_id,
//          sb_wr_row, busy, done_arb, start_err
// ---------------------------------------------------------------------------
interface oflow_score_board_rr_arbiter_if;
  import oflow_arb_pkg::*;

  logic                     start_registration;
  logic [PE_NUM-1:0]        pe_valid_mask;
  logic [ROW_LEN-1:0]       row_sel;
  logic [PE_NUM-1:0]        pe_req;
  logic [PE_NUM*ID_LEN-1:0] pe_id;
  logic [PE_NUM-1:0]        pe_grant;
  logic                     sb_wr_valid;
  logic                     sb_wr_ready;
  logic [PE_IDX_W-1:0]      sb_wr_pe;
  logic [ID_LEN-1:0]        sb_wr_id;
  logic [ROW_LEN-1:0]       sb_wr_row;
  logic                     busy;
  logic                     done_arb;
  logic                     start_err;

  modport master (
    output start_registration, pe_valid_mask, row_sel, pe_req, pe_id, sb_wr_ready,
    input  pe_grant, sb_wr_valid, sb_wr_pe, sb_wr_id, sb_wr_row, busy, done_arb, start_err
  );

  modport slave (
    input  start_registration, pe_valid_mask, row_sel, pe_req, pe_id, sb_wr_ready,
    output pe_grant, sb_wr_valid, sb_wr_pe, sb_wr_id, sb_wr_row, busy, done_arb, start_err
  );

endinterface

// File: rtl/oflow_score_board_rr_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// oflow_rr_pick
// Combinational round-robin picker: first set bit of req searching from ptr
// upward with wrap.
//   req : eligible requesters
//   ptr : search start index
//   any : at least one requester eligible
//   idx : chosen index (0 when any is low)
// ---------------------------------------------------------------------------
module oflow_rr_pick
  import oflow_arb_pkg::*;
(
  input  logic [PE_NUM-1:0]   req,
  input  logic [PE_IDX_W-1:0] ptr,
  output logic                any,
  output logic [PE_IDX_W-1:0] idx
);

  // pos[k] is the PE that sits k places after ptr; rot[k] is its request.
  logic [PE_IDX_W-1:0] pos [PE_NUM];
  logic [PE_NUM-1:0]   rot;

  genvar gi;
  generate
    for (gi = 0; gi < PE_NUM; gi++) begin : g_rot
      assign pos[gi] = (int'(ptr) + gi >= PE_NUM) ? PE_IDX_W'(int'(ptr) + gi - PE_NUM)
                                                  : PE_IDX_W'(int'(ptr) + gi);
      assign rot[gi] = req[pos[gi]];
    end
  endgenerate

  assign any = |req;

  // Scan from the far end so the entry closest to ptr wins.
  always_comb begin
    idx = '0;
    for (int k = PE_NUM - 1; k >= 0; k--) begin
      if (rot[k]) begin
        idx = pos[k];
      end
    end
  end

endmodule

// File: rtl/oflow_score_board_rr_arbiter.sv
// ---------------------------------------------------------------------------
// oflow_score_board_rr_arbiter
// Shares the single score-board write port among the PEs of one set. Each
// start_registration latches the set's valid mask and row, then serves every
// masked PE exactly once, one write at a time, in round-robin order. The
// round-robin pointer persists across rounds.
//   clk     : clock
//   reset_N : asynchronous active-low reset
//   bus     : slave view of oflow_score_board_rr_arbiter_if
//             (start/mask/row/req/id in; grant and score-board write out;
//              busy, done_arb, start_err status)
// ---------------------------------------------------------------------------
module oflow_score_board_rr_arbiter
  import oflow_arb_pkg::*;
(
  input  logic                           clk,
  input  logic                           reset_N,
  oflow_score_board_rr_arbiter_if.slave  bus
);

  arb_state_t          state_reg,   state_next;
  logic [PE_NUM-1:0]   pending_reg, pending_next;
  logic [PE_IDX_W-1:0] rr_ptr_reg,  rr_ptr_next;
  logic [PE_IDX_W-1:0] wr_pe_reg,   wr_pe_next;
  logic [ID_LEN-1:0]   wr_id_reg,   wr_id_next;
  logic [ROW_LEN-1:0]  row_reg,     row_next;

  logic [ID_LEN-1:0]   pe_id_arr [PE_NUM];
  logic                pick_any;
  logic [PE_IDX_W-1:0] pick_idx;
  logic                accept;

  genvar gi;
  generate
    for (gi = 0; gi < PE_NUM; gi++) begin : g_pe
      assign pe_id_arr[gi]   = bus.pe_id[gi*ID_LEN +: ID_LEN];
      assign bus.pe_grant[gi] = accept && (wr_pe_reg == PE_IDX_W'(gi));
    end
  endgenerate

  // Only PEs still owed a write in this round may compete.
  oflow_rr_pick u_pick (
    .req (pending_reg & bus.pe_req),
    .ptr (rr_ptr_reg),
    .any (pick_any),
    .idx (pick_idx)
  );

  assign accept = bus.sb_wr_valid && bus.sb_wr_ready;

  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      state_reg   <= IDLE;
      pending_reg <= '0;
      rr_ptr_reg  <= '0;
      wr_pe_reg   <= '0;
      wr_id_reg   <= '0;
      row_reg     <= '0;
    end else begin
      state_reg   <= state_next;
      pending_reg <= pending_next;
      rr_ptr_reg  <= rr_ptr_next;
      wr_pe_reg   <= wr_pe_next;
      wr_id_reg   <= wr_id_next;
      row_reg     <= row_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    pending_next = pending_reg;
    rr_ptr_next  = rr_ptr_reg;
    wr_pe_next   = wr_pe_reg;
    wr_id_next   = wr_id_reg;
    row_next     = row_reg;
    case (state_reg)
      IDLE: begin
        if (bus.start_registration) begin
          pending_next = bus.pe_valid_mask;
          row_next     = bus.row_sel;
          state_next   = ARB;
        end
      end
      ARB: begin
        if (pending_reg == '0) begin
          state_next = DONE;
        end else if (pick_any) begin
          // ID is captured here so a PE dropping its request mid-write is harmless.
          wr_pe_next = pick_idx;
          wr_id_next = pe_id_arr[pick_idx];
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (accept) begin
          pending_next[wr_pe_reg] = 1'b0;
          rr_ptr_next             = next_idx(wr_pe_reg);
          state_next              = ARB;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Status decoded from the state register, so reset clears them immediately.
  assign bus.sb_wr_valid = (state_reg == WAIT);
  assign bus.busy        = (state_reg == ARB) || (state_reg == WAIT);
  assign bus.done_arb    = (state_reg == DONE);
  assign bus.start_err   = bus.start_registration && (state_reg != IDLE);
  assign bus.sb_wr_pe    = wr_pe_reg;
  assign bus.sb_wr_id    = wr_id_reg;
  assign bus.sb_wr_row   = row_reg;

endmodule
